// File: rtl/decode_stage.sv
// RV32I decode stage: latches one instruction, decodes fields/immediate, reads the register file
// through a one-cycle registered port and issues the operand bundle to execute behind a busy scoreboard.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  rs1_add,
  output logic [4:0]  rs2_add,
  output logic        rd_en,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        wb_en,
  input  logic [4:0]  wb_sel,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic [6:0]  ex_funct7,
  output logic        ex_illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, OPERAND, ISSUE} state_t;

  state_t      state;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] busy;

  logic [6:0]  opcode;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        illegal;
  logic [31:0] imm;
  logic        hazard;
  logic        accept;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm     = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        use_rd  = 1'b1;
        imm     = {instr[31:12], 12'h000};
      end
      7'b1101111: begin
        use_rd  = 1'b1;
        imm     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b0001111, 7'b1110011: begin
      end
      default: illegal = 1'b1;
    endcase
  end

  // No bypass: a source whose writer is still in flight holds the instruction in DECODE.
  assign hazard = (use_rs1 && (rs1_idx != 5'd0) && busy[rs1_idx]) ||
                  (use_rs2 && (rs2_idx != 5'd0) && busy[rs2_idx]);

  assign if_ready = ((state == IDLE) || ((state == ISSUE) && ex_ready)) && !flush;
  assign accept   = if_valid && if_ready;
  assign rd_en    = (state == DECODE) && !hazard && !illegal && !flush && !rst;
  assign rs1_add  = rs1_idx;
  assign rs2_add  = rs2_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      instr      <= '0;
      pc         <= '0;
      busy       <= '0;
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
      ex_illegal <= 1'b0;
    end else begin
      if (wb_en && (wb_sel != 5'd0))
        busy[wb_sel] <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        ex_valid <= 1'b0;
        // The issued writer is squashed, so nothing will ever write its destination back.
        if ((state == ISSUE) && (ex_rd != 5'd0))
          busy[ex_rd] <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              instr <= if_instr;
              pc    <= if_pc;
              state <= DECODE;
            end
          end
          DECODE: begin
            if (!hazard)
              state <= OPERAND;
          end
          OPERAND: begin
            ex_pc      <= pc;
            ex_rs1_val <= (use_rs1 && (rs1_idx != 5'd0)) ? rs1 : 32'd0;
            ex_rs2_val <= (use_rs2 && (rs2_idx != 5'd0)) ? rs2 : 32'd0;
            ex_imm     <= imm;
            ex_rd      <= use_rd ? rd_idx : 5'd0;
            ex_opcode  <= opcode;
            ex_funct3  <= instr[14:12];
            ex_funct7  <= instr[31:25];
            ex_illegal <= illegal;
            ex_valid   <= 1'b1;
            // Placed after the writeback clear so a same-edge set on this index wins.
            if (use_rd && (rd_idx != 5'd0))
              busy[rd_idx] <= 1'b1;
            state <= ISSUE;
          end
          ISSUE: begin
            if (ex_ready) begin
              ex_valid <= 1'b0;
              if (if_valid) begin
                instr <= if_instr;
                pc    <= if_pc;
                state <= DECODE;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then random traffic
// checked every cycle against an instruction-occupancy model and an environment register file.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, if_valid, if_ready, rd_en, wb_en, ex_valid, ex_ready, ex_illegal;
  logic [31:0] if_instr, if_pc, rs1, rs2, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, wb_data;
  logic [4:0]  rs1_add, rs2_add, wb_sel, ex_rd;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_add(rs1_add), .rs2_add(rs2_add), .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
    .wb_en(wb_en), .wb_sel(wb_sel),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_illegal(ex_illegal)
  );

  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  bit chk_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Register file the stage talks to: read data registered on the rd_en edge, read-old on a same-edge write.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_en && (wb_sel != 5'd0)) begin
      rf[wb_sel] <= wb_data;
    end
    if (rd_en) begin
      rs1 <= rf[rs1_add];
      rs2 <= rf[rs2_add];
    end
  end

  typedef struct packed {
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ill;
    logic [7:0] fmt;
  } info_t;

  function automatic info_t refInfo(input logic [31:0] w);
    info_t d;
    d = '{u1: 1'b0, u2: 1'b0, wr: 1'b0, ill: 1'b0, fmt: "N"};
    case (w[6:0])
      7'h33:               begin d.u1 = 1; d.u2 = 1; d.wr = 1; d.fmt = "R"; end
      7'h13, 7'h03, 7'h67: begin d.u1 = 1; d.wr = 1; d.fmt = "I"; end
      7'h23:               begin d.u1 = 1; d.u2 = 1; d.fmt = "S"; end
      7'h63:               begin d.u1 = 1; d.u2 = 1; d.fmt = "B"; end
      7'h37, 7'h17:        begin d.wr = 1; d.fmt = "U"; end
      7'h6F:               begin d.wr = 1; d.fmt = "J"; end
      7'h0F, 7'h73:        d.fmt = "N";
      default:             d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] refImm(input logic [31:0] w, input logic [7:0] fmt);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    s = w;
    case (fmt)
      "I": begin hi = s >>> 20; return hi; end
      "S": begin hi = s >>> 25; return (hi << 5) | {27'd0, w[11:7]}; end
      "B": begin hi = s >>> 31; return (hi << 12) | {20'd0, w[7], w[30:25], w[11:8], 1'b0}; end
      "U": return w & 32'hFFFF_F000;
      "J": begin hi = s >>> 31; return (hi << 20) | {12'd0, w[19:12], w[20], w[30:21], 1'b0}; end
      default: return 32'd0;
    endcase
  endfunction

  // Model: one instruction waiting for operands (m_has), one with operands in flight (m_cap),
  // one presented to execute (m_ov), plus the set of registers with a pending write.
  bit [31:0]   m_busy;
  bit          m_has, m_cap, m_ov;
  logic [31:0] m_instr, m_pc, m_op1, m_op2;
  logic [31:0] mo_pc, mo_r1, mo_r2, mo_imm;
  logic [4:0]  mo_rd;
  logic [6:0]  mo_op, mo_f7;
  logic [2:0]  mo_f3;
  logic        mo_ill;

  function automatic bit srcBusy(input logic [4:0] idx);
    return (idx != 5'd0) && m_busy[idx];
  endfunction

  function automatic bit expHazard();
    info_t d;
    d = refInfo(m_instr);
    return (d.u1 && srcBusy(m_instr[19:15])) || (d.u2 && srcBusy(m_instr[24:20]));
  endfunction

  function automatic bit expIfReady();
    return !m_has && !m_cap && (!m_ov || ex_ready) && !flush;
  endfunction

  function automatic bit expRdEn();
    info_t d;
    d = refInfo(m_instr);
    return m_has && !expHazard() && !d.ill && !flush && !rst;
  endfunction

  always @(posedge clk) begin
    info_t d;
    bit    hz;
    bit    acc;
    d   = refInfo(m_instr);
    hz  = expHazard();
    acc = if_valid && expIfReady();
    if (rst) begin
      m_busy = '0;
      m_has  = 0;
      m_cap  = 0;
      m_ov   = 0;
    end else begin
      if (wb_en && (wb_sel != 5'd0)) m_busy[wb_sel] = 1'b0;
      if (flush) begin
        if (m_ov) m_busy[mo_rd] = 1'b0;
        m_has = 0;
        m_cap = 0;
        m_ov  = 0;
      end else begin
        if (m_ov && ex_ready) m_ov = 0;
        if (m_cap) begin
          mo_pc  = m_pc;
          mo_r1  = m_op1;
          mo_r2  = m_op2;
          mo_imm = refImm(m_instr, d.fmt);
          mo_rd  = d.wr ? m_instr[11:7] : 5'd0;
          mo_op  = m_instr[6:0];
          mo_f3  = m_instr[14:12];
          mo_f7  = m_instr[31:25];
          mo_ill = d.ill;
          if (mo_rd != 5'd0) m_busy[mo_rd] = 1'b1;
          m_ov  = 1;
          m_cap = 0;
        end
        if (m_has && !hz) begin
          m_op1 = (d.u1 && m_instr[19:15] != 5'd0) ? rf[m_instr[19:15]] : 32'd0;
          m_op2 = (d.u2 && m_instr[24:20] != 5'd0) ? rf[m_instr[24:20]] : 32'd0;
          m_has = 0;
          m_cap = 1;
        end
        if (acc) begin
          m_has   = 1;
          m_instr = if_instr;
          m_pc    = if_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rd_en) rd_pulses++;
    if (chk_en) begin
      checkOutput("if_ready", {31'd0, if_ready}, {31'd0, expIfReady()});
      checkOutput("rd_en", {31'd0, rd_en}, {31'd0, expRdEn()});
      if (expRdEn()) begin
        checkOutput("rs1_add", {27'd0, rs1_add}, {27'd0, m_instr[19:15]});
        checkOutput("rs2_add", {27'd0, rs2_add}, {27'd0, m_instr[24:20]});
      end
      checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, m_ov});
      if (m_ov) begin
        checkOutput("ex_pc", ex_pc, mo_pc);
        checkOutput("ex_rs1_val", ex_rs1_val, mo_r1);
        checkOutput("ex_rs2_val", ex_rs2_val, mo_r2);
        checkOutput("ex_imm", ex_imm, mo_imm);
        checkOutput("ex_rd", {27'd0, ex_rd}, {27'd0, mo_rd});
        checkOutput("ex_opcode", {25'd0, ex_opcode}, {25'd0, mo_op});
        checkOutput("ex_funct3", {29'd0, ex_funct3}, {29'd0, mo_f3});
        checkOutput("ex_funct7", {25'd0, ex_funct7}, {25'd0, mo_f7});
        checkOutput("ex_illegal", {31'd0, ex_illegal}, {31'd0, mo_ill});
      end
      checkOutput("busy", dut.busy, m_busy);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
    bit got;
    got      = 0;
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (if_ready) got = 1;
      sync();
    end
    if_valid = 1'b0;
    if (!got) begin
      fails++;
      $display("[TB] FAIL accept_timeout: got no if_ready in 50 cycles, expected acceptance");
    end
  endtask

  task automatic waitIssue(output int n);
    bit got;
    got = 0;
    n   = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      n++;
      if (ex_valid) got = 1;
    end
    if (!got) begin
      fails++;
      $display("[TB] FAIL issue_timeout: got no ex_valid in 50 cycles, expected an issue");
    end
  endtask

  task automatic writeback(input logic [4:0] idx, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_sel  = idx;
    wb_data = data;
    sync();
    wb_en   = 1'b0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73};
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 11);
    if (k < 11) w[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) begin
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      w[11:7]  = 5'($urandom_range(0, 7));
    end
    return w;
  endfunction

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    logic [31:0] imm_instr [4] = '{32'hFE512C23, 32'hFE000EE3, 32'hABCDE537, 32'hFFDFF06F};
    logic [31:0] imm_exp   [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'hABCDE000, 32'hFFFFFFFC};
    logic [4:0]  rd_exp    [4] = '{5'd0, 5'd0, 5'd10, 5'd0};

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; wb_en = 1'b0; wb_sel = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    checkOutput("reset_if_ready", {31'd0, if_ready}, 32'd1);
    checkOutput("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_rd_en", {31'd0, rd_en}, 32'd0);
    checkOutput("reset_ex_imm", ex_imm, 32'd0);
    checkOutput("reset_rs_add", {22'd0, rs1_add, rs2_add}, 32'd0);
    sync();

    // add x7,x5,x0 with x5 preloaded
    writeback(5'd5, 32'hDEADBEEF);
    applyStimulus(32'h000283B3, 32'h0000_0100);
    waitIssue(n);
    checkOutput("add_latency_edges", 32'(n - 1), 32'd2);
    checkOutput("add_rs1_val", ex_rs1_val, 32'hDEADBEEF);
    checkOutput("add_rs2_val", ex_rs2_val, 32'd0);
    checkOutput("add_rd", {27'd0, ex_rd}, 32'd7);
    checkOutput("add_busy7", {31'd0, dut.busy[7]}, 32'd1);
    sync();
    writeback(5'd7, 32'h0000_0007);

    // addi x1,x0,-1 followed by dependent add x2,x1,x1
    applyStimulus(32'hFFF00093, 32'h0000_0104);
    waitIssue(n);
    checkOutput("addi_imm", ex_imm, 32'hFFFFFFFF);
    sync();
    applyStimulus(32'h00108133, 32'h0000_0108);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("stall_rd_en", {31'd0, rd_en}, 32'd0);
      sync();
    end
    wb_en = 1'b1; wb_sel = 5'd1; wb_data = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("stall_wb_cycle_rd_en", {31'd0, rd_en}, 32'd0);
    sync();
    wb_en = 1'b0;
    @(negedge clk);
    checkOutput("after_wb_rd_en", {31'd0, rd_en}, 32'd1);
    waitIssue(n);
    checkOutput("dep_rs1_val", ex_rs1_val, 32'h0BADF00D);
    checkOutput("dep_rs2_val", ex_rs2_val, 32'h0BADF00D);
    sync();
    writeback(5'd2, 32'h0000_0000);

    // sw, beq, lui, jal immediates
    for (int k = 0; k < 4; k++) begin
      applyStimulus(imm_instr[k], 32'h0000_0200 + 32'(4 * k));
      waitIssue(n);
      checkOutput("imm_value", ex_imm, imm_exp[k]);
      checkOutput("imm_rd", {27'd0, ex_rd}, {27'd0, rd_exp[k]});
      sync();
    end
    writeback(5'd10, 32'h0000_000A);

    // all-zero word is illegal
    pulses = rd_pulses;
    applyStimulus(32'h0000_0000, 32'h0000_0300);
    waitIssue(n);
    checkOutput("illegal_flag", {31'd0, ex_illegal}, 32'd1);
    checkOutput("illegal_rd", {27'd0, ex_rd}, 32'd0);
    checkOutput("illegal_rd_en_pulses", 32'(rd_pulses - pulses), 32'd0);
    checkOutput("illegal_busy", dut.busy, 32'd0);
    sync();

    // execute back-pressure then flush
    ex_ready = 1'b0;
    applyStimulus(32'h000283B3, 32'h0000_0400);
    waitIssue(n);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_ex_valid", {31'd0, ex_valid}, 32'd1);
      checkOutput("hold_if_ready", {31'd0, if_ready}, 32'd0);
      checkOutput("hold_rs1_val", ex_rs1_val, 32'hDEADBEEF);
      checkOutput("hold_pc", ex_pc, 32'h0000_0400);
      @(negedge clk);
    end
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_if_ready", {31'd0, if_ready}, 32'd1);
    checkOutput("flush_busy7", {31'd0, dut.busy[7]}, 32'd0);
    sync();

    // writeback of x3 on the edge a new x3 writer leaves OPERAND
    applyStimulus(32'h00500193, 32'h0000_0500);
    waitIssue(n);
    sync();
    applyStimulus(32'h00700193, 32'h0000_0504);
    sync();
    wb_en = 1'b1; wb_sel = 5'd3; wb_data = 32'h0000_0005;
    sync();
    wb_en = 1'b0;
    @(negedge clk);
    checkOutput("same_edge_busy3", {31'd0, dut.busy[3]}, 32'd1);
    sync();
    writeback(5'd3, 32'h0000_0007);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = randInstr();
      if_pc    = $urandom() & 32'hFFFF_FFFC;
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_en    = ($urandom_range(0, 2) == 0);
      wb_sel   = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wb_data  = $urandom();
      flush    = ($urandom_range(0, 29) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      sync();
    end
    if_valid = 1'b0; ex_ready = 1'b1; wb_en = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (4) sync();

    // reset while an instruction sits in DECODE
    applyStimulus(32'hABCDE537, 32'h0000_0600);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("midreset_if_ready", {31'd0, if_ready}, 32'd1);
    checkOutput("midreset_busy", dut.busy, 32'd0);
    checkOutput("midreset_ex_imm", ex_imm, 32'd0);
    repeat (3) sync();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the multi-cycle RV32I core, sitting between fetch and execute. It accepts one instruction per handshake and decodes fields and immediate. It drives the register file's read port (`rs1_add`, `rs2_add`, `rd_en`) and captures the operands one cycle later. A 32-entry busy scoreboard stalls on pending writes to a source register, and the decoded bundle is presented to execute with a valid/ready handshake.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush (branch/trap redirect).
- `if_valid`  in  1  fetch presents instruction.
- `if_ready`  out  1  decode accepts this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  instruction PC.
- `rs1_add`  out  5  register-file read address 1.
- `rs2_add`  out  5  register-file read address 2.
- `rd_en`  out  1  register-file read enable. The file registers the read data on the same edge.
- `rs1`  in  32  register-file read data 1, valid the cycle after `rd_en`.
- `rs2`  in  32  register-file read data 2, valid the cycle after `rd_en`.
- `wb_en`  in  1  writeback snoop: write enable going to the register file.
- `wb_sel`  in  5  writeback snoop: destination index.
- `ex_valid` / `ex_ready`  out / in  1  handshake to execute.
- `ex_pc`  out  32  PC of the issued instruction.
- `ex_rs1_val`, `ex_rs2_val`  out  32  operand values.
- `ex_imm`  out  32  sign-extended immediate.
- `ex_rd`  out  5  destination index; 0 if the instruction does not write.
- `ex_opcode`  out  7  opcode field.
- `ex_funct3`  out  3  funct3 field.
- `ex_funct7`  out  7  funct7 field.
- `ex_illegal`  out  1  instruction is not a legal RV32I encoding.

## Operation
- States: IDLE, DECODE, OPERAND, ISSUE.
- `if_ready` = (IDLE) | (ISSUE & `ex_ready`) and is forced 0 while `flush`. On acceptance, latch instr/pc and go to DECODE.
- Source/destination use by opcode:
  - 0110011: rs1, rs2, rd
  - 0010011, 0000011, 1100111: rs1, rd
  - 0100011, 1100011: rs1, rs2
  - 0110111, 0010111, 1101111: rd
  - 0001111, 1110011: none
  - any other opcode, or instr[1:0]≠11: illegal, no sources, `ex_rd`=0
- Immediate selection:
  - I-type: loads, OP-IMM, JALR
  - S-type: store
  - B-type: branch
  - U-type: LUI, AUIPC
  - J-type: JAL
  - All immediates sign-extended; 0 for R-type, FENCE, SYSTEM and illegal.
- DECODE: if any used source with index ≠0 has its busy bit set, stay (stall) with `rd_en`=0. Otherwise assert `rd_en` for one cycle with `rs1_add`/`rs2_add` = instruction fields, then go to OPERAND.
- OPERAND: capture `rs1`/`rs2` into `ex_rs1_val`/`ex_rs2_val`. The value is forced to 0 when the index is 0 or the source is unused. Set `ex_valid`, set `busy[ex_rd]` if `ex_rd`≠0, go to ISSUE.
- ISSUE: hold all `ex_*` stable while `ex_valid` & !`ex_ready`. On handshake:
  - if `if_valid`, accept the next instruction and go to DECODE;
  - otherwise clear `ex_valid` and go to IDLE.
- Scoreboard: `busy[wb_sel]` is cleared on any edge with `wb_en` and `wb_sel`≠0. `busy[0]` is always 0.
  - Set and clear of the same index on the same edge: set wins.
  - No bypass. A stall still holds in the cycle `wb_en` is asserted; the read issues no earlier than the following cycle.
- Flush (priority over all handshakes):
  - next state IDLE, `ex_valid`←0, latched instruction dropped;
  - if the current state is ISSUE, clear `busy[ex_rd]`;
  - other busy bits are kept, since older writes are still in flight.

## Timing
- Reset values:
  - state IDLE, `if_ready`=1;
  - `ex_valid`=0, `rd_en`=0, all busy bits 0;
  - all `ex_*` data outputs 0, `rs1_add`/`rs2_add`=0.
- Latency, accept edge to `ex_valid` high: 2 cycles with no hazard. Each stall cycle adds 1.
- Best-case throughput: 1 instruction per 3 cycles with `ex_ready` held high.
- `rd_en` is high for exactly one cycle per instruction and never in IDLE/OPERAND/ISSUE.
- Reset mid-operation: returns to the reset state on the next edge; in-flight instruction discarded.

## Test plan
- Program x5=0xDEADBEEF, feed `add x7,x5,x0` (0x000283B3) → after 2 cycles `ex_rs1_val`=0xDEADBEEF, `ex_rs2_val`=0, `ex_rd`=7, busy[7]=1.
- Feed `addi x1,x0,-1` then `add x2,x1,x1` with no writeback → second instruction stalls in DECODE with `rd_en`=0. Pulse `wb_en`/`wb_sel`=1 → `rd_en` asserts on the following cycle.
- Feed `sw`, `beq`, `lui`, `jal` with known fields → `ex_imm` matches the S/B/U/J sign-extended values (e.g. `jal x0,-4` → 0xFFFFFFFC) and `ex_rd`=0 for sw/beq.
- Feed 0x00000000 → `ex_illegal`=1, `ex_rd`=0, no `rd_en`, busy unchanged.
- Hold `ex_ready`=0 for 5 cycles in ISSUE → `ex_*` stable and `if_ready`=0. Assert `flush` → IDLE next edge, `ex_valid`=0, busy[`ex_rd`] cleared.
- Same-edge `wb_en` to x3 while an OPERAND for a new writer of x3 completes → busy[3] remains 1.
